// File: rtl/vdp_compositor.sv
// vdp_compositor: sprite-over-background pixel compositor with an AHB-Lite
// register block, a frame counter and a frame interrupt.
// The optional collision detector is built only when the macro
// VDP_COMPOSITOR_COLLISION_EN is defined. Without the macro, COLLISION reads 0.
module vdp_compositor #(
  parameter int N_SPRITES = 8,
  parameter int RGB_WIDTH = 3
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [31:0]                    HADDR,
  input  logic [1:0]                     HTRANS,
  input  logic                           HSEL,
  input  logic                           HWRITE,
  input  logic                           HREADY,
  input  logic [31:0]                    HWDATA,
  output logic [31:0]                    HRDATA,
  output logic                           HREADYOUT,
  output logic                           HRESP,
  input  logic [N_SPRITES-1:0]           sprite_rgb_en,
  input  logic [N_SPRITES*RGB_WIDTH-1:0] sprite_rgb,
  input  logic                           display_on,
  input  logic                           frame_end,
  output logic [RGB_WIDTH-1:0]           rgb,
  output logic                           irq
);

  localparam logic [2:0] OFS_CTRL      = 3'd0;
  localparam logic [2:0] OFS_BG_COLOR  = 3'd1;
  localparam logic [2:0] OFS_MASK      = 3'd2;
  localparam logic [2:0] OFS_COLLISION = 3'd3;
  localparam logic [2:0] OFS_FRAME_CNT = 3'd4;
  localparam logic [2:0] OFS_IRQ_ACK   = 3'd5;

  // Highest-index enabled sprite wins; background when no sprite is enabled.
  function automatic logic [RGB_WIDTH-1:0] pick_colour(
    input logic [N_SPRITES-1:0]           en,
    input logic [N_SPRITES*RGB_WIDTH-1:0] colours,
    input logic [RGB_WIDTH-1:0]           bg
  );
    logic [RGB_WIDTH-1:0] c;
    c = bg;
    for (int i = 0; i < N_SPRITES; i++) begin
      if (en[i]) begin
        c = colours[i*RGB_WIDTH +: RGB_WIDTH];
      end else begin
        c = c;
      end
    end
    return c;
  endfunction

  // AHB data-phase tracking
  logic                 dph_valid_q, dph_valid_d;
  logic                 dph_write_q, dph_write_d;
  logic [2:0]           dph_addr_q,  dph_addr_d;
  // Register file
  logic                 irq_en_q,    irq_en_d;
  logic [RGB_WIDTH-1:0] bg_q,        bg_d;
  logic [N_SPRITES-1:0] mask_q,      mask_d;
  logic [15:0]          frame_cnt_q, frame_cnt_d;
  logic                 irq_pend_q,  irq_pend_d;
  // Pixel pipeline
  logic [N_SPRITES-1:0]           s1_en_q,   s1_en_d;
  logic [N_SPRITES*RGB_WIDTH-1:0] s1_rgb_q,  s1_rgb_d;
  logic                           s1_disp_q, s1_disp_d;
  logic [RGB_WIDTH-1:0]           rgb_q,     rgb_d;

  logic                 wr_en_s;
  logic [N_SPRITES-1:0] collision_s;
  logic                 unused_bits;

  // Address-phase only feeds HADDR[4:2]; the rest of the bus is decoded elsewhere.
  assign unused_bits = ^{HADDR[31:5], HADDR[1:0], HTRANS[0], HWDATA};

  assign wr_en_s   = dph_valid_q && dph_write_q;
  assign HREADYOUT = 1'b1;
  assign HRESP     = 1'b0;
  assign rgb       = rgb_q;
  assign irq       = irq_pend_q;

  // Next-state for bus tracking, register writes, frame counter, irq and pixel pipeline.
  always_comb begin
    dph_valid_d = dph_valid_q;
    dph_write_d = dph_write_q;
    dph_addr_d  = dph_addr_q;
    irq_en_d    = irq_en_q;
    bg_d        = bg_q;
    mask_d      = mask_q;
    frame_cnt_d = frame_cnt_q;
    irq_pend_d  = irq_pend_q;

    if (HREADY) begin
      dph_valid_d = HSEL && HTRANS[1];
      dph_write_d = HWRITE;
      dph_addr_d  = HADDR[4:2];
    end else begin
      dph_valid_d = dph_valid_q;
    end

    if (wr_en_s) begin
      case (dph_addr_q)
        OFS_CTRL:     irq_en_d = HWDATA[0];
        OFS_BG_COLOR: bg_d     = HWDATA[RGB_WIDTH-1:0];
        OFS_MASK:     mask_d   = HWDATA[N_SPRITES-1:0];
        default:      irq_en_d = irq_en_q;
      endcase
    end else begin
      irq_en_d = irq_en_q;
    end

    if (frame_end) begin
      frame_cnt_d = frame_cnt_q + 16'd1;
    end else begin
      frame_cnt_d = frame_cnt_q;
    end

    // A frame_end with interrupts enabled beats a simultaneous acknowledge.
    if (frame_end && irq_en_q) begin
      irq_pend_d = 1'b1;
    end else if (wr_en_s && (dph_addr_q == OFS_IRQ_ACK)) begin
      irq_pend_d = 1'b0;
    end else begin
      irq_pend_d = irq_pend_q;
    end

    s1_en_d   = sprite_rgb_en & mask_q;
    s1_rgb_d  = sprite_rgb;
    s1_disp_d = display_on;
    if (s1_disp_q) begin
      rgb_d = pick_colour(s1_en_q, s1_rgb_q, bg_q);
    end else begin
      rgb_d = '0;
    end
  end

  // Read mux driven from the registered data-phase address.
  always_comb begin
    HRDATA = 32'd0;
    case (dph_addr_q)
      OFS_CTRL:      HRDATA = {31'd0, irq_en_q};
      OFS_BG_COLOR:  HRDATA = 32'(bg_q);
      OFS_MASK:      HRDATA = 32'(mask_q);
      OFS_COLLISION: HRDATA = 32'(collision_s);
      OFS_FRAME_CNT: HRDATA = {16'd0, frame_cnt_q};
      default:       HRDATA = 32'd0;
    endcase
  end

  // State registers; reset also drops any in-flight data phase.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dph_valid_q <= 1'b0;
      dph_write_q <= 1'b0;
      dph_addr_q  <= 3'd0;
      irq_en_q    <= 1'b0;
      bg_q        <= '0;
      mask_q      <= '1;
      frame_cnt_q <= 16'd0;
      irq_pend_q  <= 1'b0;
      s1_en_q     <= '0;
      s1_rgb_q    <= '0;
      s1_disp_q   <= 1'b0;
      rgb_q       <= '0;
    end else begin
      dph_valid_q <= dph_valid_d;
      dph_write_q <= dph_write_d;
      dph_addr_q  <= dph_addr_d;
      irq_en_q    <= irq_en_d;
      bg_q        <= bg_d;
      mask_q      <= mask_d;
      frame_cnt_q <= frame_cnt_d;
      irq_pend_q  <= irq_pend_d;
      s1_en_q     <= s1_en_d;
      s1_rgb_q    <= s1_rgb_d;
      s1_disp_q   <= s1_disp_d;
      rgb_q       <= rgb_d;
    end
  end

`ifdef VDP_COMPOSITOR_COLLISION_EN
  // True when two or more bits are set.
  function automatic logic multi_hit(input logic [N_SPRITES-1:0] v);
    return (v & (v - N_SPRITES'(1))) != '0;
  endfunction

  logic [N_SPRITES-1:0] coll_q, coll_d;
  logic [N_SPRITES-1:0] live_q, live_d;
  logic [N_SPRITES-1:0] hit_s;

  // Accumulate overlaps over the frame, then hand them to COLLISION at frame_end.
  always_comb begin
    coll_d = coll_q;
    live_d = live_q;
    if (s1_disp_q && multi_hit(s1_en_q)) begin
      hit_s = s1_en_q;
    end else begin
      hit_s = '0;
    end
    if (wr_en_s && (dph_addr_q == OFS_COLLISION)) begin
      coll_d = coll_q & ~HWDATA[N_SPRITES-1:0];
    end else begin
      coll_d = coll_q;
    end
    if (frame_end) begin
      coll_d = coll_d | live_q | hit_s;
      live_d = '0;
    end else begin
      live_d = live_q | hit_s;
    end
  end

  // Collision state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      coll_q <= '0;
      live_q <= '0;
    end else begin
      coll_q <= coll_d;
      live_q <= live_d;
    end
  end

  assign collision_s = coll_q;
`else
  assign collision_s = '0;
`endif

endmodule

// File: doc/vdp_compositor.md
VDP_COMPOSITOR -- requirements
Module: vdp_compositor

Interface
REQ-001 SHALL have parameter N_SPRITES, default 8, number of sprite channels (2..32).
REQ-002 SHALL have parameter RGB_WIDTH, default 3, bits per pixel colour.
REQ-003 SHALL have port clk  input  1  system clock; all state on rising edge.
REQ-004 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have AHB-Lite slave inputs HADDR[31:0], HTRANS[1:0], HSEL, HWRITE, HREADY, HWDATA[31:0].
REQ-006 SHALL have AHB-Lite outputs HRDATA[31:0], HREADYOUT (constant 1), HRESP (constant 0).
REQ-007 SHALL have port sprite_rgb_en  input  N_SPRITES  per-sprite pixel-hit flags.
REQ-008 SHALL have port sprite_rgb  input  N_SPRITES*RGB_WIDTH  packed sprite colours, sprite i at bits [i*RGB_WIDTH +: RGB_WIDTH].
REQ-009 SHALL have port display_on  input  1  active video region.
REQ-010 SHALL have port frame_end  input  1  single-cycle pulse, once per frame.
REQ-011 SHALL have port rgb  output  RGB_WIDTH  composited pixel.
REQ-012 SHALL have port irq  output  1  frame interrupt, level.

Function
REQ-013 SHALL accept an AHB transfer when HSEL && HREADY && HTRANS[1]; address (HADDR[4:2]) and HWRITE registered for the data phase; writes use HWDATA in the data phase.
REQ-014 SHALL decode word offsets: 0x00 CTRL (bit0 irq_en), 0x04 BG_COLOR, 0x08 SPRITE_MASK, 0x0C COLLISION, 0x10 FRAME_COUNT (read-only, 16 bits), 0x14 IRQ_ACK (write-only).
REQ-015 SHALL drive HRDATA combinationally from the registered data-phase address, zero-extended; unmapped offsets and IRQ_ACK read 0.
REQ-016 SHALL form masked_en = sprite_rgb_en & SPRITE_MASK[N_SPRITES-1:0].
REQ-017 SHALL pipeline pixels in two stages: stage 1 registers masked_en, sprite_rgb, display_on; stage 2 registers rgb; latency exactly 2 cycles.
REQ-018 SHALL select the highest-index set masked_en bit's colour; if none set, BG_COLOR[RGB_WIDTH-1:0]; if stage-1 display_on is 0, rgb = 0.
REQ-019 SHALL increment FRAME_COUNT on each frame_end, wrapping 0xFFFF -> 0x0000.
REQ-020 SHALL set irq_pending on frame_end when irq_en = 1; irq = irq_pending.
REQ-021 SHALL clear irq_pending on any write to IRQ_ACK; simultaneous frame_end (with irq_en) wins, pending stays 1.
REQ-022 SHALL keep irq_pending set when irq_en is later cleared; only IRQ_ACK clears it.
REQ-023 SHALL ignore writes to FRAME_COUNT and unmapped offsets.

Reset
REQ-024 SHALL on reset clear CTRL, BG_COLOR, FRAME_COUNT, COLLISION, collision_live, irq_pending, pipeline registers, rgb; set SPRITE_MASK to all ones.
REQ-025 SHALL abandon any in-flight AHB data phase on reset; no register write occurs.

Configuration
REQ-026 SHALL compile collision detection in only when macro VDP_COMPOSITOR_COLLISION_EN is defined.
REQ-027 SHALL, with the macro, OR stage-1 masked_en into collision_live whenever stage-1 display_on and two or more bits are set.
REQ-028 SHALL, with the macro, OR collision_live into COLLISION and clear collision_live on frame_end; on the same cycle, a hit is included in the transfer.
REQ-029 SHALL, with the macro, clear COLLISION bits written 1; set from frame_end wins over simultaneous clear.
REQ-030 SHALL, without the macro, read COLLISION as 0 and contain no collision logic.

Verification
REQ-031 Reset, then no sprites, display_on=1, BG_COLOR=5 -> rgb=5 two cycles after display_on; display_on=0 -> rgb=0.
REQ-032 sprite_rgb_en=0x81, sprite 7 colour 2, sprite 0 colour 6 -> rgb=2; SPRITE_MASK=0x7F -> rgb=6.
REQ-033 Overlap of sprites 1 and 3 during display, then frame_end -> COLLISION reads 0x0A; write 0x08 -> reads 0x02 (macro on); reads 0 with macro off.
REQ-034 CTRL=1, frame_end -> irq=1; IRQ_ACK write same cycle as next frame_end -> irq stays 1; IRQ_ACK alone -> irq=0.
REQ-035 65536 frame_end pulses from reset -> FRAME_COUNT reads 0; one more -> 1.
REQ-036 Reset asserted mid write to BG_COLOR -> BG_COLOR reads 0, SPRITE_MASK reads 0xFF, irq=0.
